// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-ported memory between the core port and the program-loader port.
// Latency: ack is issued 2 cycles after the IDLE edge that grants the request; at most one access every 3 cycles.
// Backpressure: each requester holds req and its operands until its one-cycle ack; ldr_lock blocks only new core grants.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    input  logic          ldr_lock,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          win_ldr;
    logic [DW-1:0] core_hold, ldr_hold;
    logic          core_gnt, ldr_gnt, pick_ldr, grant;

    // win_ldr doubles as the round-robin history: the last winner is the in-flight winner.
    assign core_gnt = core_req & ~ldr_lock;
    assign ldr_gnt  = ldr_req;
    assign pick_ldr = ldr_gnt & (~core_gnt | ~win_ldr);
    assign grant    = (state == IDLE) & (core_gnt | ldr_gnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        core_ack  = 1'b0;
        ldr_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (core_gnt || ldr_gnt) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = lat_we;
                state_nxt = RESP;
            end
            RESP: begin
                core_ack  = ~win_ldr;
                ldr_ack   = win_ldr;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            win_ldr   <= 1'b1;
            core_hold <= '0;
            ldr_hold  <= '0;
        end else begin
            if (grant) begin
                win_ldr   <= pick_ldr;
                lat_we    <= pick_ldr ? ldr_we    : core_we;
                lat_addr  <= pick_ldr ? ldr_addr  : core_addr;
                lat_wdata <= pick_ldr ? ldr_wdata : core_wdata;
            end
            if (state == RESP && !lat_we) begin
                if (win_ldr) begin
                    ldr_hold <= mem_rdata;
                end else begin
                    core_hold <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    // Read data is forwarded straight from memory during RESP, then served from the holding register.
    assign core_rdata = (state == RESP && !win_ldr && !lat_we) ? mem_rdata : core_hold;
    assign ldr_rdata  = (state == RESP &&  win_ldr && !lat_we) ? mem_rdata : ldr_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences and a randomized two-requester run.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_ack;
    logic [DW-1:0] core_rdata;
    logic          ldr_req = 1'b0, ldr_we = 1'b0;
    logic [AW-1:0] ldr_addr = '0;
    logic [DW-1:0] ldr_wdata = '0;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;
    logic          ldr_lock = 1'b0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_lock(ldr_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Shared memory: read data appears the cycle after mem_en.
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[11:2]];
        end
    end

    wire  [1:0]    ack_v = {ldr_ack, core_ack};
    logic [31:0]   rd_v [2];
    assign rd_v[0] = core_rdata;
    assign rd_v[1] = ldr_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] hold_m [2];
    logic [31:0] ref_mem [logic [31:0]];

    typedef struct {
        bit          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input bit p, input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (p == 1'b0) begin
            core_req = r; core_we = we; core_addr = a; core_wdata = d;
        end else begin
            ldr_req = r; ldr_we = we; ldr_addr = a; ldr_wdata = d;
        end
    endtask

    // Issues one access from an idle arbiter and follows it to its ack.
    task automatic do_access(input bit p, input logic we, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output int lat);
        int en_cycles;
        en_cycles = 0;
        lat = 0;
        rd = '0;
        @(negedge clk);
        set_port(p, 1'b1, we, a, d);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cycles++;
                check("mem_addr", mem_addr, a);
                check("mem_we", {31'b0, mem_we}, {31'b0, we});
                if (we) check("mem_wdata", mem_wdata, d);
            end
            check("other_ack", {31'b0, ack_v[!p]}, 32'h0);
            check("other_rdata", rd_v[!p], hold_m[!p]);
            if (ack_v[p]) begin
                lat = n;
                rd = rd_v[p];
                break;
            end
            check("own_rdata_hold", rd_v[p], hold_m[p]);
        end
        set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
        if (lat == 0) check("ack_timeout", 32'h0, 32'h1);
        check("mem_en_cycles", en_cycles, 1);
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    logic [31:0] rd;
    int          lat;
    int          ack_n [$];
    bit          ack_p [$];
    bit          pend [2];
    logic        pwe [2];
    logic [31:0] paddr [2];
    logic [31:0] pdata [2];
    int          wait_n [2];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'h200, 32'h55AA55AA, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h55AA55AA};
        vecs[4]  = '{1'b0, 1'b1, 32'h10,  32'h12345678, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b1, 32'h200, 32'h0BADF00D, 32'h55AA55AA};
        vecs[6]  = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h0BADF00D};
        vecs[7]  = '{1'b0, 1'b0, 32'h200, 32'h0,        32'h0BADF00D};
        vecs[8]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'h12345678};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFC, 32'hFFFFFFFF, 32'h0BADF00D};
        vecs[10] = '{1'b0, 1'b0, 32'hFFC, 32'h0,        32'hFFFFFFFF};
        hold_m[0] = 32'h0;
        hold_m[1] = 32'h0;

        // Reset state
        #1 reset = 1'b0;
        #11;
        check("rst_mem_en", {31'b0, mem_en}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_acks", {30'b0, ack_v}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_core_rdata", core_rdata, 32'h0);
        check("rst_ldr_rdata", ldr_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vector table, one isolated access each
        foreach (vecs[i]) begin
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
            check("vec_latency", lat, 2);
            check("vec_rdata", rd, vecs[i].exp);
            hold_m[vecs[i].port] = vecs[i].exp;
            @(negedge clk);
            check("vec_rdata_after", rd_v[vecs[i].port], vecs[i].exp);
        end

        // Both ports requesting continuously from reset release: strict alternation, core first
        @(negedge clk);
        reset = 1'b0;
        set_port(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_port(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (core_ack) begin ack_n.push_back(n); ack_p.push_back(1'b0); end
            if (ldr_ack)  begin ack_n.push_back(n); ack_p.push_back(1'b1); end
        end
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rr_ack_count", ack_n.size(), 4);
        for (int k = 0; k < 4 && k < ack_n.size(); k++) begin
            check("rr_ack_cycle", ack_n[k], 2 + 3 * k);
            check("rr_ack_port", {31'b0, ack_p[k]}, k % 2);
        end
        check("rr_core_rdata", core_rdata, 32'h12345678);
        check("rr_ldr_rdata", ldr_rdata, 32'h0BADF00D);
        hold_m[0] = 32'h12345678;
        hold_m[1] = 32'h0BADF00D;

        // Loader lock: loader write proceeds, pending core read waits for unlock
        ldr_lock = 1'b1;
        set_port(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        do_access(1'b1, 1'b1, 32'h200, 32'h55AA55AA, rd, lat);
        check("lock_ldr_latency", lat, 2);
        check("lock_ldr_rdata", rd, 32'h0BADF00D);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("lock_no_core_ack", {31'b0, core_ack}, 32'h0);
            check("lock_no_mem_en", {31'b0, mem_en}, 32'h0);
        end
        ldr_lock = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (core_ack) begin lat = n; check("unlock_core_rdata", core_rdata, 32'h12345678); break; end
        end
        check("unlock_core_latency", lat, 2);
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during ACCESS aborts the core read; the reissue completes
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        check("abort_in_access", {31'b0, mem_en}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("abort_mem_en", {31'b0, mem_en}, 32'h0);
        check("abort_core_ack", {31'b0, core_ack}, 32'h0);
        check("abort_core_rdata", core_rdata, 32'h0);
        check("abort_ldr_rdata", ldr_rdata, 32'h0);
        hold_m[0] = 32'h0;
        hold_m[1] = 32'h0;
        @(negedge clk);
        check("abort_no_ack", {30'b0, ack_v}, 32'h0);
        reset = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (core_ack) begin lat = n; check("reissue_rdata", core_rdata, 32'h55AA55AA); break; end
        end
        check("reissue_latency", lat, 2);
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        hold_m[0] = 32'h55AA55AA;

        // Loader write then read of the same address
        do_access(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, rd, lat);
        check("lw_rdata_unchanged", rd, 32'h0);
        do_access(1'b1, 1'b0, 32'h40, 32'h0, rd, lat);
        check("lr_rdata", rd, 32'hCAFEF00D);
        hold_m[1] = 32'hCAFEF00D;
        check("lr_core_rdata", core_rdata, 32'h55AA55AA);

        // Randomized traffic against a transaction-level memory model
        for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; wait_n[p] = 0; end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            check("rand_dual_ack", {31'b0, core_ack & ldr_ack}, 32'h0);
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) wait_n[p]++;
                if (ack_v[p]) begin
                    if (!pend[p]) begin
                        check("rand_spurious_ack", 32'h1, 32'h0);
                    end else begin
                        check("rand_wait_bound", {31'b0, wait_n[p] <= 6}, 32'h1);
                        if (pwe[p]) begin
                            ref_mem[paddr[p]] = pdata[p];
                            check("rand_w_rdata", rd_v[p], hold_m[p]);
                        end else begin
                            check("rand_r_rdata", rd_v[p], ref_rd(paddr[p]));
                            hold_m[p] = ref_rd(paddr[p]);
                        end
                        pend[p] = 1'b0;
                        set_port(p[0], 1'b0, 1'b0, 32'h0, 32'h0);
                    end
                end else begin
                    check("rand_hold", rd_v[p], hold_m[p]);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 3) != 0) begin
                    pend[p]   = 1'b1;
                    wait_n[p] = 0;
                    pwe[p]    = $urandom_range(0, 1) == 1;
                    paddr[p]  = 32'h800 + 32'($urandom_range(0, 7)) * 4;
                    pdata[p]  = $urandom;
                    set_port(p[0], 1'b1, pwe[p], paddr[p], pdata[p]);
                end
            end
        end
        set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameters (name, default, meaning): AW, 32, address width; DW, 32, data width.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 core_req, core_we  input  1 each  core access request (level) and write qualifier.
REQ-005 core_addr  input  AW; core_wdata  input  DW  core access address and write data.
REQ-006 core_ack  output  1  one-cycle completion pulse; core_rdata  output  DW  core read data.
REQ-007 ldr_req, ldr_we  input  1 each; ldr_addr  input  AW; ldr_wdata  input  DW  program-loader port, same meaning as the core port.
REQ-008 ldr_ack  output  1; ldr_rdata  output  DW  loader completion pulse and read data.
REQ-009 ldr_lock  input  1  loader-exclusive mode: core requests not granted while high.
REQ-010 mem_en, mem_we  output  1 each  shared-memory access enable and write enable.
REQ-011 mem_addr  output  AW; mem_wdata  output  DW; mem_rdata  input  DW  shared memory; read data valid the cycle after mem_en.

Function
REQ-012 The block SHALL implement states IDLE, ACCESS, RESP with transitions IDLE->ACCESS (at least one grantable request), ACCESS->RESP (unconditional), RESP->IDLE (unconditional).
REQ-013 In IDLE, requests SHALL be sampled on the rising edge; the winner's we, addr and wdata SHALL be latched into internal registers, and the winner's identity recorded.
REQ-014 Arbitration SHALL be round-robin: with both requests grantable, the port not granted last SHALL win; with one grantable request, that port SHALL win.
REQ-015 core_req SHALL be non-grantable while ldr_lock is high; an access already past IDLE SHALL complete regardless of ldr_lock changes.
REQ-016 In ACCESS, mem_en SHALL be 1, and mem_we, mem_addr and mem_wdata SHALL equal the latched values; in IDLE and RESP, mem_en and mem_we SHALL be 0.
REQ-017 In RESP, exactly the winner's ack SHALL be 1 for that single cycle; the other ack SHALL be 0.
REQ-018 For a read, the winner's rdata SHALL equal mem_rdata during RESP, and mem_rdata SHALL be captured into that port's holding register at the end of RESP.
REQ-019 Outside its RESP cycle, each port's rdata SHALL present its holding register; writes SHALL NOT modify the holding register.
REQ-020 Latency SHALL be fixed: ack asserts 2 cycles after the IDLE edge that granted the request; the maximum rate is one access per 3 cycles.
REQ-021 Requesters SHALL hold req, we, addr and wdata stable until ack; req still high in the RESP cycle SHALL NOT be treated as a new request, because only IDLE samples.
REQ-022 A port that is re-requesting SHALL wait at most one other access (3 cycles) when the other port also requests continuously and ldr_lock is low.
REQ-023 Request changes during ACCESS or RESP SHALL NOT alter the in-flight access.

Reset
REQ-024 reset low SHALL immediately force: state IDLE; mem_en, mem_we, core_ack and ldr_ack 0; mem_addr, mem_wdata and latched registers 0; both holding registers 0; last-granted = loader, so the core wins the first tie.
REQ-025 Reset asserted mid-access SHALL abort the access with no ack issued; the requester SHALL reissue the access after reset release.
REQ-026 The first arbitration after reset release SHALL occur on the first rising edge with reset high.

Verification
REQ-027 Core read, addr 0x10, memory holds 0xDEADBEEF -> mem_en=1 with mem_addr=0x10 one cycle later; core_ack=1 with core_rdata=0xDEADBEEF the following cycle; core_rdata holds afterward.
REQ-028 core_req and ldr_req both high from reset release -> grant order core, ldr, core, ldr; acks 3 cycles apart.
REQ-029 ldr_lock=1, ldr write 0x55AA55AA to 0x200 with core_req high -> mem_we=1, mem_wdata=0x55AA55AA; no core_ack until the IDLE cycle after ldr_lock drops.
REQ-030 Reset pulsed low during ACCESS of a core read -> mem_en drops immediately; no core_ack; core_rdata=0; the reissued read completes normally.
REQ-031 Loader write followed by loader read of the same address -> ldr_rdata unchanged by the write; the read returns the written value; core_rdata never changes.
